// File: rtl/tl_control_responder_if.sv
// Channel A/D signal bundle for the control-crossing TileLink-UL link.
// The master drives requests and consumes responses; the slave answers.
interface tl_control_responder_if;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_bits_opcode;
    logic [2:0]  a_bits_param;
    logic [1:0]  a_bits_size;
    logic [10:0] a_bits_source;
    logic [28:0] a_bits_address;
    logic [7:0]  a_bits_mask;
    logic [63:0] a_bits_data;
    logic        a_bits_corrupt;

    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_size;
    logic [10:0] d_bits_source;
    logic [63:0] d_bits_data;

    modport master (
        input  a_ready,
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
        output a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        output d_ready,
        input  d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_data
    );

    modport slave (
        output a_ready,
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
        input  a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        input  d_ready,
        output d_valid, d_bits_opcode, d_bits_size, d_bits_source, d_bits_data
    );
endinterface

// File: rtl/tl_control_responder.sv
// TileLink-UL single-beat responder: bank of 64-bit control registers plus a
// read-only request counter in the last slot, with a one-entry D response register.
module tl_control_responder #(
    parameter logic [28:0] BASE_ADDR = 29'h000_2000,
    parameter int unsigned NREGS     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_control_responder_if.slave bus
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned LANES  = 8;
    localparam int unsigned NRW    = NREGS - 1;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    logic [DATA_W-1:0] r_regs [NRW];
    logic [DATA_W-1:0] r_count;
    logic              r_d_valid;
    logic [2:0]        r_d_opcode;
    logic [1:0]        r_d_size;
    logic [10:0]       r_d_source;
    logic [DATA_W-1:0] r_d_data;

    logic [DATA_W-1:0] w_regs_nxt [NRW];
    logic [DATA_W-1:0] w_count_nxt;
    logic              w_d_valid_nxt;
    logic [2:0]        w_d_opcode_nxt;
    logic [1:0]        w_d_size_nxt;
    logic [10:0]       w_d_source_nxt;
    logic [DATA_W-1:0] w_d_data_nxt;

    logic              w_a_ready;
    logic              w_a_fire;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_is_put;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused;

    // Single-entry response slot: accept whenever it is empty or draining now.
    assign w_a_ready = !r_d_valid || bus.d_ready;
    assign w_a_fire  = bus.a_valid && w_a_ready;

    assign w_hit    = (bus.a_bits_address[28:6] == BASE_ADDR[28:6]);
    assign w_idx    = bus.a_bits_address[5:3];
    assign w_is_put = (bus.a_bits_opcode == OP_PUT_FULL) || (bus.a_bits_opcode == OP_PUT_PART);
    assign w_wr_en  = w_a_fire && w_is_put && w_hit && !bus.a_bits_corrupt
                      && (w_idx != IDX_W'(NRW));

    // Sub-word position and param carry no meaning here; lanes come from the mask.
    assign w_unused = ^{bus.a_bits_param, bus.a_bits_address[2:0]};

    // Slot select; the top index falls through to the counter.
    always_comb begin
        w_rd_data = r_count;
        for (int unsigned s = 0; s < NRW; s++) begin
            if (w_idx == IDX_W'(s)) begin
                w_rd_data = r_regs[s];
            end
        end
    end

    // Byte-lane merge into the addressed read/write slot.
    always_comb begin
        for (int unsigned s = 0; s < NRW; s++) begin
            w_regs_nxt[s] = r_regs[s];
        end
        for (int unsigned s = 0; s < NRW; s++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                if (w_wr_en && (w_idx == IDX_W'(s)) && bus.a_bits_mask[l]) begin
                    w_regs_nxt[s][8*l +: 8] = bus.a_bits_data[8*l +: 8];
                end
            end
        end
    end

    assign w_count_nxt = w_a_fire ? (r_count + DATA_W'(1)) : r_count;

    // Response slot: reload on fire, retire on d_ready, otherwise hold.
    always_comb begin
        w_d_valid_nxt  = r_d_valid;
        w_d_opcode_nxt = r_d_opcode;
        w_d_size_nxt   = r_d_size;
        w_d_source_nxt = r_d_source;
        w_d_data_nxt   = r_d_data;
        if (w_a_fire) begin
            w_d_valid_nxt  = 1'b1;
            w_d_size_nxt   = bus.a_bits_size;
            w_d_source_nxt = bus.a_bits_source;
            if (bus.a_bits_opcode == OP_GET) begin
                w_d_opcode_nxt = OP_ACK_DATA;
                w_d_data_nxt   = w_hit ? w_rd_data : '0;
            end else begin
                w_d_opcode_nxt = OP_ACK;
                w_d_data_nxt   = '0;
            end
        end else if (bus.d_ready) begin
            w_d_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < NRW; s++) begin
                r_regs[s] <= '0;
            end
            r_count    <= '0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_data   <= '0;
        end else begin
            for (int unsigned s = 0; s < NRW; s++) begin
                r_regs[s] <= w_regs_nxt[s];
            end
            r_count    <= w_count_nxt;
            r_d_valid  <= w_d_valid_nxt;
            r_d_opcode <= w_d_opcode_nxt;
            r_d_size   <= w_d_size_nxt;
            r_d_source <= w_d_source_nxt;
            r_d_data   <= w_d_data_nxt;
        end
    end

    assign bus.a_ready       = w_a_ready;
    assign bus.d_valid       = r_d_valid;
    assign bus.d_bits_opcode = r_d_opcode;
    assign bus.d_bits_size   = r_d_size;
    assign bus.d_bits_source = r_d_source;
    assign bus.d_bits_data   = r_d_data;

endmodule

// File: tb/tb_tl_control_responder.sv
// Bench for tl_control_responder: transaction-level model with a per-cycle
// compare process, directed literal checks, and a randomized traffic phase.
module tb_tl_control_responder;

    logic clock;
    logic reset;

    tl_control_responder_if bus();

    tl_control_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_regs [8];
    logic [63:0] m_count;
    bit          m_dv;
    logic [2:0]  m_op;
    logic [1:0]  m_size;
    logic [10:0] m_src;
    logic [63:0] m_data;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 64'h0;
            m_count = 64'h0;
            m_dv    = 1'b0;
        end else begin
            bit          fire;
            bit          hit;
            int          idx;
            logic [2:0]  op;
            fire = bus.a_valid && (!m_dv || bus.d_ready);
            if (fire) begin
                op  = bus.a_bits_opcode;
                hit = (bus.a_bits_address >> 6) == (29'h2000 >> 6);
                idx = int'(bus.a_bits_address[5:3]);
                m_dv   = 1'b1;
                m_size = bus.a_bits_size;
                m_src  = bus.a_bits_source;
                if (op == 3'd4) begin
                    m_op   = 3'd1;
                    m_data = !hit ? 64'h0 : (idx == 7 ? m_count : m_regs[idx]);
                end else begin
                    m_op   = 3'd0;
                    m_data = 64'h0;
                    if ((op == 3'd0 || op == 3'd1) && hit && idx != 7 && !bus.a_bits_corrupt)
                        for (int l = 0; l < 8; l++)
                            if (bus.a_bits_mask[l]) m_regs[idx][8*l +: 8] = bus.a_bits_data[8*l +: 8];
                end
                m_count = m_count + 64'd1;
            end else if (m_dv && bus.d_ready) begin
                m_dv = 1'b0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        if (!reset) begin
            chk("model a_ready", 64'(bus.a_ready), 64'(!m_dv || bus.d_ready));
            chk("model d_valid", 64'(bus.d_valid), 64'(m_dv));
            if (m_dv) begin
                chk("model d_opcode", 64'(bus.d_bits_opcode), 64'(m_op));
                chk("model d_size",   64'(bus.d_bits_size),   64'(m_size));
                chk("model d_source", 64'(bus.d_bits_source), 64'(m_src));
                chk("model d_data",   bus.d_bits_data,        m_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [2:0] op, input logic [28:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic cor, input logic [10:0] src);
        bit fired = 1'b0;
        int n = 0;
        bus.a_bits_opcode  = op;
        bus.a_bits_param   = 3'($urandom);
        bus.a_bits_size    = 2'd3;
        bus.a_bits_source  = src;
        bus.a_bits_address = addr;
        bus.a_bits_mask    = mask;
        bus.a_bits_data    = data;
        bus.a_bits_corrupt = cor;
        bus.a_valid        = 1'b1;
        while (!fired && n < 100) begin
            @(negedge clock);
            fired = bus.a_ready;
            @(posedge clock);
            n++;
        end
        #1 bus.a_valid = 1'b0;
        if (!fired) chk("send timeout", 64'd0, 64'd1);
    endtask

    task automatic check_resp(input string name, input logic [2:0] op, input logic [10:0] src,
                              input logic [63:0] data);
        @(negedge clock);
        chk({name, " valid"},  64'(bus.d_valid),       64'd1);
        chk({name, " opcode"}, 64'(bus.d_bits_opcode), 64'(op));
        chk({name, " source"}, 64'(bus.d_bits_source), 64'(src));
        chk({name, " data"},   bus.d_bits_data,        data);
        @(posedge clock);
        #1;
    endtask

    task automatic rand_req();
        int sel = $urandom_range(0, 9);
        bus.a_bits_opcode  = (sel < 3) ? 3'd4 : (sel < 5) ? 3'd0 : (sel < 7) ? 3'd1 : 3'($urandom);
        bus.a_bits_param   = 3'($urandom);
        bus.a_bits_size    = 2'($urandom);
        bus.a_bits_source  = 11'($urandom);
        bus.a_bits_address = ($urandom_range(0, 3) != 0) ? {23'h80, 6'($urandom)} : 29'($urandom);
        bus.a_bits_mask    = 8'($urandom);
        bus.a_bits_data    = {$urandom, $urandom};
        bus.a_bits_corrupt = ($urandom_range(0, 7) == 0);
        bus.a_valid        = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit fired;
        reset              = 1'b1;
        bus.a_valid        = 1'b0;
        bus.a_bits_opcode  = 3'd0;
        bus.a_bits_param   = 3'd0;
        bus.a_bits_size    = 2'd0;
        bus.a_bits_source  = 11'd0;
        bus.a_bits_address = 29'd0;
        bus.a_bits_mask    = 8'd0;
        bus.a_bits_data    = 64'd0;
        bus.a_bits_corrupt = 1'b0;
        bus.d_ready        = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset a_ready", 64'(bus.a_ready), 64'd1);
        chk("reset d_valid", 64'(bus.d_valid), 64'd0);
        @(posedge clock);
        #1;

        send(3'd4, 29'h2000, 8'hFF, 64'h0, 1'b0, 11'h7FF);
        check_resp("get idle", 3'd1, 11'h7FF, 64'h0);

        send(3'd0, 29'h2008, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 11'h001);
        check_resp("putfull ack", 3'd0, 11'h001, 64'h0);
        send(3'd0, 29'h2010, 8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, 11'h002);
        send(3'd4, 29'h2010, 8'hFF, 64'h0, 1'b0, 11'h003);
        check_resp("b2b get", 3'd1, 11'h003, 64'hDEADBEEFCAFEF00D);
        send(3'd4, 29'h2008, 8'hFF, 64'h0, 1'b0, 11'h004);
        check_resp("get 2008", 3'd1, 11'h004, 64'h0123456789ABCDEF);

        send(3'd0, 29'h2018, 8'hFF, 64'h11111111_22222222, 1'b0, 11'h005);
        send(3'd1, 29'h2018, 8'h0F, 64'hFFFFFFFF_AAAAAAAA, 1'b0, 11'h006);
        send(3'd4, 29'h2018, 8'hFF, 64'h0, 1'b0, 11'h007);
        check_resp("partial", 3'd1, 11'h007, 64'h11111111_AAAAAAAA);

        send(3'd4, 29'h3000, 8'hFF, 64'h0, 1'b0, 11'h008);
        check_resp("miss", 3'd1, 11'h008, 64'h0);
        send(3'd0, 29'h2008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 11'h009);
        check_resp("corrupt ack", 3'd0, 11'h009, 64'h0);
        send(3'd4, 29'h2008, 8'hFF, 64'h0, 1'b0, 11'h00A);
        check_resp("corrupt kept", 3'd1, 11'h00A, 64'h0123456789ABCDEF);
        send(3'd2, 29'h2008, 8'hFF, 64'h5555, 1'b0, 11'h00B);
        check_resp("op2 ack", 3'd0, 11'h00B, 64'h0);

        // Back-pressure: response held, a_ready low, D stable.
        bus.d_ready = 1'b0;
        send(3'd4, 29'h2008, 8'hFF, 64'h0, 1'b0, 11'h011);
        bus.a_bits_opcode  = 3'd0;
        bus.a_bits_source  = 11'h022;
        bus.a_bits_address = 29'h2020;
        bus.a_bits_data    = 64'h77;
        bus.a_valid        = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("bp a_ready", 64'(bus.a_ready), 64'd0);
            chk("bp d_valid", 64'(bus.d_valid), 64'd1);
            chk("bp source",  64'(bus.d_bits_source), 64'h011);
            chk("bp data",    bus.d_bits_data, 64'h0123456789ABCDEF);
            @(posedge clock);
        end
        #1 bus.d_ready = 1'b1;
        @(negedge clock);
        chk("release a_ready", 64'(bus.a_ready), 64'd1);
        chk("release source",  64'(bus.d_bits_source), 64'h011);
        @(posedge clock);
        #1 bus.a_valid = 1'b0;
        @(negedge clock);
        chk("release next source", 64'(bus.d_bits_source), 64'h022);
        chk("release next opcode", 64'(bus.d_bits_opcode), 64'd0);
        @(posedge clock);
        #1;

        // Counter after a fresh reset.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) send(3'd4, 29'h2000, 8'hFF, 64'h0, 1'b0, 11'(i));
        send(3'd4, 29'h2038, 8'hFF, 64'h0, 1'b0, 11'h100);
        check_resp("counter 5", 3'd1, 11'h100, 64'd5);
        send(3'd0, 29'h2038, 8'hFF, 64'hFFFF, 1'b0, 11'h101);
        send(3'd4, 29'h2038, 8'hFF, 64'h0, 1'b0, 11'h102);
        check_resp("counter 7", 3'd1, 11'h102, 64'd7);

        // Randomized traffic with TileLink hold-until-accepted on A.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clock);
            fired = bus.a_valid && bus.a_ready;
            @(posedge clock);
            #1;
            bus.d_ready = ($urandom_range(0, 3) != 0);
            if (fired || !bus.a_valid) begin
                if ($urandom_range(0, 4) != 0) rand_req();
                else bus.a_valid = 1'b0;
            end
        end
        bus.a_valid = 1'b0;
        bus.d_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Reset while a response is held.
        bus.d_ready = 1'b0;
        send(3'd4, 29'h2008, 8'hFF, 64'h0, 1'b0, 11'h055);
        @(negedge clock);
        chk("pre-reset d_valid", 64'(bus.d_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset d_valid", 64'(bus.d_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        bus.d_ready = 1'b1;
        @(negedge clock);
        chk("post-reset a_ready", 64'(bus.a_ready), 64'd1);
        chk("post-reset d_valid", 64'(bus.d_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
